mips_mc_controller: RTL and testbench
=====================================

# mips_mc_controller

Multicycle successor to the single-cycle MIPS control unit. A Moore state machine sequences each instruction over 3–5 cycles, or 2+MD_LATENCY cycles for mult/div, through a shared-memory, shared-ALU datapath. It also drives HI/LO register control and counts the latency of a multi-cycle mult/div unit. It sits beside the multicycle datapath, which owns the PC, IR, ALUOut and the HI/LO registers.

## Interface
Parameters:
- INSTR_WITDTH, 32, instruction width
- ALU_CTRL_WIDTH, 4, ALU control width
- REG_WR_SRC_WIDTH, 2, register-file write-source select width
- HI_LO_SEL_WIDTH, 2, HI/LO input select width
- MD_LATENCY, 32, cycles a mult/div occupies; legal range ≥1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- instr  in  INSTR_WITDTH  IR contents; the datapath holds this stable outside FETCH
- zero  in  1  ALU zero flag
- pcen  out  1  PC write enable
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- irwrite  out  1  IR load
- memwrite  out  1  data memory write
- regdst  out  1  destination register: 0 = rt, 1 = rd
- regwrite  out  1  register-file write
- alusrca  out  1  ALU A input: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B input: 00 = rt, 01 = 4, 10 = signimm, 11 = signimm<<2
- pcsrc  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs
- alucontrl  out  ALU_CTRL_WIDTH  ALU operation
- select_regwrite  out  REG_WR_SRC_WIDTH  write-back source: 00 = ALUOut, 01 = memory, 10 = HI, 11 = LO
- hi_write, lo_write  out  1 each  HI/LO register write enables
- hi_select, lo_select  out  HI_LO_SEL_WIDTH each  HI/LO input select: 01 = rs, 10 = div, 11 = mult
- md_busy  out  1  mult/div in progress
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct

## Operation
- All outputs are decoded from the state register only; no output depends combinationally on `zero`, except `pcen` in BRANCH.
- Any output not listed for a state is 0.
- ALU codes:
  - add = 0010, sub = 0110, and = 0000, or = 0001, xor = 0011, nor = 0100, slt = 0111
  - sll = 1000, srl = 1001, sra = 1010, sllv = 1011, srlv = 1100, srav = 1101
- States, with their asserted outputs and next state:
  - RST: all outputs 0 → FETCH.
  - FETCH: irwrite, pcen, alusrcb = 01, add → DECODE.
  - DECODE: alusrcb = 11, add. Dispatch on opcode/funct:
    - lw/sw → MEMADR
    - R-type ALU → EXEC
    - addi → ADDIEX
    - beq → BRANCH
    - j → JUMP
    - jr (funct 001000) → JR
    - mfhi/mflo → HLRD
    - mthi/mtlo → HLWR
    - mult/div → MDWAIT; counter loads MD_LATENCY-1
    - anything else → ILLEGAL
  - MEMADR: alusrca, alusrcb = 10, add → MEMRD (lw) or MEMWR (sw).
  - MEMRD: iord → MEMWB.
  - MEMWB: regwrite, select_regwrite = 01 → FETCH.
  - MEMWR: iord, memwrite → FETCH.
  - EXEC: alusrca, alucontrl decoded from funct → ALUWB.
  - ALUWB: regdst, regwrite → FETCH.
  - ADDIEX: alusrca, alusrcb = 10, add → ADDIWB.
  - ADDIWB: regwrite → FETCH.
  - BRANCH: alusrca, sub, pcsrc = 01, pcen = zero → FETCH.
  - JUMP: pcsrc = 10, pcen → FETCH.
  - JR: pcsrc = 11, pcen → FETCH.
  - HLRD: regdst, regwrite, select_regwrite = 10 (mfhi) or 11 (mflo) → FETCH.
  - HLWR: mthi asserts hi_write with hi_select = 01; mtlo asserts lo_write with lo_select = 01 → FETCH.
  - MDWAIT: md_busy. Counter decrements each cycle. On the cycle the count is 0, assert hi_write and lo_write, with both selects = 11 (mult) or 10 (div), then → FETCH.
  - ILLEGAL: illegal → FETCH. The PC has already advanced, so execution continues at the next instruction.
- Counter width is $clog2(MD_LATENCY+1). The counter never wraps: it leaves MDWAIT at 0.
- An R-type funct outside the supported set goes to ILLEGAL, never to EXEC.

## Timing
- While rst_n = 0 at a clock edge, the state register becomes RST; all outputs are 0 in the following cycle. The first FETCH occurs one cycle after rst_n rises.
- Cycle counts per instruction:
  - lw: 5
  - sw, R-type, addi: 4
  - mfhi/mflo, mthi/mtlo, beq, j, jr: 3
  - illegal: 3
  - mult/div: 2 + MD_LATENCY; HI/LO are written in the last cycle
- Reset mid-MDWAIT or mid-instruction: the state returns to RST and no hi_write, lo_write, regwrite or memwrite is issued for the aborted instruction.
- `illegal` and `pcen` are high for exactly one cycle per occurrence.
- md_busy is high for exactly MD_LATENCY cycles per mult/div.

## Configuration
- MIPS_MC_HILO_EN defined: mult, div, mfhi, mflo, mthi and mtlo are decoded as described above.
- MIPS_MC_HILO_EN undefined:
  - those six functs go to ILLEGAL
  - the HLRD, HLWR and MDWAIT states and the counter are absent
  - hi_write, lo_write, hi_select, lo_select and md_busy are tied to 0
  - select_regwrite[1] is tied to 0

## Test plan
- Reset mid-FETCH: hold rst_n = 0 for 2 cycles → all outputs 0 for one cycle after release, then FETCH with irwrite = pcen = 1.
- lw 0x8C080004 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles. MEMRD has iord = 1; MEMWB has regwrite = 1 and select_regwrite = 01.
- beq 0x11090002: with zero = 1, BRANCH asserts pcen = 1 and pcsrc = 01; with zero = 0, pcen stays 0. Both take 3 cycles.
- mult 0x01090018 with MD_LATENCY = 4 → md_busy high for 4 cycles; hi_write = lo_write = 1 with both selects 11 only in the 4th; total 6 cycles.
- div in progress, rst_n pulsed low in the 2nd MDWAIT cycle → no hi_write/lo_write pulse, RST state, then FETCH.
- Opcode 0x3F, and separately R-type funct 0x3F → illegal = 1 for one cycle in the 3rd cycle, no register or memory write. With MIPS_MC_HILO_EN undefined, mfhi also produces illegal.

Source files
------------

// File: rtl/mips_mc_controller_if.sv
// rtl/mips_mc_controller_if.sv - control bus between the multicycle MIPS controller and its datapath
interface mips_mc_controller_if #(
    parameter int INSTR_WITDTH     = 32,
    parameter int ALU_CTRL_WIDTH   = 4,
    parameter int REG_WR_SRC_WIDTH = 2,
    parameter int HI_LO_SEL_WIDTH  = 2
);
    logic [INSTR_WITDTH-1:0]     instr;
    logic                        zero;
    logic                        pcen;
    logic                        iord;
    logic                        irwrite;
    logic                        memwrite;
    logic                        regdst;
    logic                        regwrite;
    logic                        alusrca;
    logic [1:0]                  alusrcb;
    logic [1:0]                  pcsrc;
    logic [ALU_CTRL_WIDTH-1:0]   alucontrl;
    logic [REG_WR_SRC_WIDTH-1:0] select_regwrite;
    logic                        hi_write;
    logic                        lo_write;
    logic [HI_LO_SEL_WIDTH-1:0]  hi_select;
    logic [HI_LO_SEL_WIDTH-1:0]  lo_select;
    logic                        md_busy;
    logic                        illegal;

    modport master (
        input  instr, zero,
        output pcen, iord, irwrite, memwrite, regdst, regwrite, alusrca, alusrcb, pcsrc,
               alucontrl, select_regwrite, hi_write, lo_write, hi_select, lo_select,
               md_busy, illegal
    );

    modport slave (
        output instr, zero,
        input  pcen, iord, irwrite, memwrite, regdst, regwrite, alusrca, alusrcb, pcsrc,
               alucontrl, select_regwrite, hi_write, lo_write, hi_select, lo_select,
               md_busy, illegal
    );
endinterface

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multicycle MIPS control FSM with registered Moore outputs
// MIPS_MC_HILO_EN adds mult/div sequencing and HI/LO moves; undefined, those functs are illegal.
module mips_mc_controller #(
    parameter int INSTR_WITDTH     = 32,
    parameter int ALU_CTRL_WIDTH   = 4,
    parameter int REG_WR_SRC_WIDTH = 2,
    parameter int HI_LO_SEL_WIDTH  = 2,
    parameter int MD_LATENCY       = 32
) (
    input  logic clk,
    input  logic rst_n,
    mips_mc_controller_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_JR = 6'h08;
`ifdef MIPS_MC_HILO_EN
    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_DIV = 6'h1A;
    localparam int SRW_W = REG_WR_SRC_WIDTH;
    localparam int CNT_W = $clog2(MD_LATENCY + 1);
`else
    localparam int SRW_W = 1;
    localparam int unused_md_latency = MD_LATENCY;
`endif

    typedef enum logic [4:0] {
        S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC, S_ALUWB,
        S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_JR, S_ILLEGAL
`ifdef MIPS_MC_HILO_EN
        , S_HLRD, S_HLWR, S_MDWAIT
`endif
    } state_t;

    typedef struct packed {
        logic                      pcen;
        logic                      iord;
        logic                      irwrite;
        logic                      memwrite;
        logic                      regdst;
        logic                      regwrite;
        logic                      alusrca;
        logic [1:0]                alusrcb;
        logic [1:0]                pcsrc;
        logic [ALU_CTRL_WIDTH-1:0] alucontrl;
        logic [SRW_W-1:0]          select_regwrite;
        logic                      illegal;
`ifdef MIPS_MC_HILO_EN
        logic                       hi_write;
        logic                       lo_write;
        logic [HI_LO_SEL_WIDTH-1:0] hi_select;
        logic [HI_LO_SEL_WIDTH-1:0] lo_select;
        logic                       md_busy;
`endif
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
`ifdef MIPS_MC_HILO_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic [5:0]                opcode;
    logic [5:0]                funct;
    logic                      alu_ok;
    logic [ALU_CTRL_WIDTH-1:0] alu_code;
    logic                      unused_instr;

    assign opcode       = bus.instr[INSTR_WITDTH-1 -: 6];
    assign funct        = bus.instr[5:0];
    assign unused_instr = ^bus.instr[INSTR_WITDTH-7:6];

    always_comb begin
        alu_ok   = 1'b1;
        alu_code = '0;
        case (funct)
            6'h20:   alu_code = ALU_CTRL_WIDTH'(4'b0010);
            6'h22:   alu_code = ALU_CTRL_WIDTH'(4'b0110);
            6'h24:   alu_code = ALU_CTRL_WIDTH'(4'b0000);
            6'h25:   alu_code = ALU_CTRL_WIDTH'(4'b0001);
            6'h26:   alu_code = ALU_CTRL_WIDTH'(4'b0011);
            6'h27:   alu_code = ALU_CTRL_WIDTH'(4'b0100);
            6'h2A:   alu_code = ALU_CTRL_WIDTH'(4'b0111);
            6'h00:   alu_code = ALU_CTRL_WIDTH'(4'b1000);
            6'h02:   alu_code = ALU_CTRL_WIDTH'(4'b1001);
            6'h03:   alu_code = ALU_CTRL_WIDTH'(4'b1010);
            6'h04:   alu_code = ALU_CTRL_WIDTH'(4'b1011);
            6'h06:   alu_code = ALU_CTRL_WIDTH'(4'b1100);
            6'h07:   alu_code = ALU_CTRL_WIDTH'(4'b1101);
            default: alu_ok   = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
`ifdef MIPS_MC_HILO_EN
        cnt_d = cnt_q;
`endif
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_RTYPE: begin
                        if (funct == F_JR)
                            state_d = S_JR;
                        else if (alu_ok)
                            state_d = S_EXEC;
`ifdef MIPS_MC_HILO_EN
                        else if (funct == F_MFHI || funct == F_MFLO)
                            state_d = S_HLRD;
                        else if (funct == F_MTHI || funct == F_MTLO)
                            state_d = S_HLWR;
                        else if (funct == F_MULT || funct == F_DIV) begin
                            state_d = S_MDWAIT;
                            cnt_d   = CNT_W'(MD_LATENCY - 1);
                        end
`endif
                        else
                            state_d = S_ILLEGAL;
                    end
                    default: state_d = S_ILLEGAL;
                endcase
            end
`ifdef MIPS_MC_HILO_EN
            // Count saturates at zero; that cycle performs the HI/LO write and exits.
            S_MDWAIT: begin
                if (cnt_q != '0) begin
                    state_d = S_MDWAIT;
                    cnt_d   = cnt_q - 1'b1;
                end
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs are decoded for the upcoming state so they leave a register.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH: begin
                ctrl_d.irwrite   = 1'b1;
                ctrl_d.pcen      = 1'b1;
                ctrl_d.alusrcb   = 2'b01;
                ctrl_d.alucontrl = ALU_CTRL_WIDTH'(4'b0010);
            end
            S_DECODE: begin
                ctrl_d.alusrcb   = 2'b11;
                ctrl_d.alucontrl = ALU_CTRL_WIDTH'(4'b0010);
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_d.alusrca   = 1'b1;
                ctrl_d.alusrcb   = 2'b10;
                ctrl_d.alucontrl = ALU_CTRL_WIDTH'(4'b0010);
            end
            S_MEMRD: ctrl_d.iord = 1'b1;
            S_MEMWB: begin
                ctrl_d.regwrite        = 1'b1;
                ctrl_d.select_regwrite = SRW_W'(1);
            end
            S_MEMWR: begin
                ctrl_d.iord     = 1'b1;
                ctrl_d.memwrite = 1'b1;
            end
            S_EXEC: begin
                ctrl_d.alusrca   = 1'b1;
                ctrl_d.alucontrl = alu_code;
            end
            S_ALUWB: begin
                ctrl_d.regdst   = 1'b1;
                ctrl_d.regwrite = 1'b1;
            end
            S_ADDIWB: ctrl_d.regwrite = 1'b1;
            S_BRANCH: begin
                ctrl_d.alusrca   = 1'b1;
                ctrl_d.alucontrl = ALU_CTRL_WIDTH'(4'b0110);
                ctrl_d.pcsrc     = 2'b01;
            end
            S_JUMP: begin
                ctrl_d.pcsrc = 2'b10;
                ctrl_d.pcen  = 1'b1;
            end
            S_JR: begin
                ctrl_d.pcsrc = 2'b11;
                ctrl_d.pcen  = 1'b1;
            end
            S_ILLEGAL: ctrl_d.illegal = 1'b1;
`ifdef MIPS_MC_HILO_EN
            S_HLRD: begin
                ctrl_d.regdst          = 1'b1;
                ctrl_d.regwrite        = 1'b1;
                ctrl_d.select_regwrite = (funct == F_MFHI) ? SRW_W'(2) : SRW_W'(3);
            end
            S_HLWR: begin
                if (funct == F_MTHI) begin
                    ctrl_d.hi_write  = 1'b1;
                    ctrl_d.hi_select = HI_LO_SEL_WIDTH'(2'b01);
                end else begin
                    ctrl_d.lo_write  = 1'b1;
                    ctrl_d.lo_select = HI_LO_SEL_WIDTH'(2'b01);
                end
            end
            S_MDWAIT: begin
                ctrl_d.md_busy = 1'b1;
                if (cnt_d == '0) begin
                    ctrl_d.hi_write  = 1'b1;
                    ctrl_d.lo_write  = 1'b1;
                    ctrl_d.hi_select = (funct == F_DIV) ? HI_LO_SEL_WIDTH'(2'b10) : HI_LO_SEL_WIDTH'(2'b11);
                    ctrl_d.lo_select = (funct == F_DIV) ? HI_LO_SEL_WIDTH'(2'b10) : HI_LO_SEL_WIDTH'(2'b11);
                end
            end
`endif
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RST;
            ctrl_q  <= '0;
`ifdef MIPS_MC_HILO_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
`ifdef MIPS_MC_HILO_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.pcen            = ctrl_q.pcen | ((state_q == S_BRANCH) & bus.zero);
    assign bus.iord            = ctrl_q.iord;
    assign bus.irwrite         = ctrl_q.irwrite;
    assign bus.memwrite        = ctrl_q.memwrite;
    assign bus.regdst          = ctrl_q.regdst;
    assign bus.regwrite        = ctrl_q.regwrite;
    assign bus.alusrca         = ctrl_q.alusrca;
    assign bus.alusrcb         = ctrl_q.alusrcb;
    assign bus.pcsrc           = ctrl_q.pcsrc;
    assign bus.alucontrl       = ctrl_q.alucontrl;
    assign bus.select_regwrite = REG_WR_SRC_WIDTH'(ctrl_q.select_regwrite);
    assign bus.illegal         = ctrl_q.illegal;
`ifdef MIPS_MC_HILO_EN
    assign bus.hi_write  = ctrl_q.hi_write;
    assign bus.lo_write  = ctrl_q.lo_write;
    assign bus.hi_select = ctrl_q.hi_select;
    assign bus.lo_select = ctrl_q.lo_select;
    assign bus.md_busy   = ctrl_q.md_busy;
`else
    assign bus.hi_write  = 1'b0;
    assign bus.lo_write  = 1'b0;
    assign bus.hi_select = HI_LO_SEL_WIDTH'(0);
    assign bus.lo_select = HI_LO_SEL_WIDTH'(0);
    assign bus.md_busy   = 1'b0;
`endif
endmodule

// File: tb/tb_mips_mc_controller.sv
// tb/tb_mips_mc_controller.sv - scoreboard bench for the multicycle MIPS controller (MD_LATENCY = 4)
module tb_mips_mc_controller;
    typedef struct packed {
        logic       pcen, iord, irwrite, memwrite, regdst, regwrite, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [3:0] alu;
        logic [1:0] srw;
        logic       hi_w, lo_w;
        logic [1:0] hi_s, lo_s;
        logic       busy, illegal;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mips_mc_controller_if bus ();

    mips_mc_controller #(.MD_LATENCY(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic obs_t model(string st, logic [3:0] alu, logic z, logic [1:0] sel);
        obs_t o;
        o = '0;
        case (st)
            "FETCH":   begin o.irwrite = 1; o.pcen = 1; o.alusrcb = 2'b01; o.alu = 4'b0010; end
            "DECODE":  begin o.alusrcb = 2'b11; o.alu = 4'b0010; end
            "MEMADR":  begin o.alusrca = 1; o.alusrcb = 2'b10; o.alu = 4'b0010; end
            "ADDIEX":  begin o.alusrca = 1; o.alusrcb = 2'b10; o.alu = 4'b0010; end
            "MEMRD":   o.iord = 1;
            "MEMWB":   begin o.regwrite = 1; o.srw = 2'b01; end
            "MEMWR":   begin o.iord = 1; o.memwrite = 1; end
            "EXEC":    begin o.alusrca = 1; o.alu = alu; end
            "ALUWB":   begin o.regdst = 1; o.regwrite = 1; end
            "ADDIWB":  o.regwrite = 1;
            "BRANCH":  begin o.alusrca = 1; o.alu = 4'b0110; o.pcsrc = 2'b01; o.pcen = z; end
            "JUMP":    begin o.pcsrc = 2'b10; o.pcen = 1; end
            "JR":      begin o.pcsrc = 2'b11; o.pcen = 1; end
            "ILLEGAL": o.illegal = 1;
            "HLRD":    begin o.regdst = 1; o.regwrite = 1; o.srw = sel; end
            "HLWR_HI": begin o.hi_w = 1; o.hi_s = 2'b01; end
            "HLWR_LO": begin o.lo_w = 1; o.lo_s = 2'b01; end
            "MDWAIT":  o.busy = 1;
            "MDLAST":  begin o.busy = 1; o.hi_w = 1; o.lo_w = 1; o.hi_s = sel; o.lo_s = sel; end
            default:   o = '0;
        endcase
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.pcen = bus.pcen;         o.iord = bus.iord;       o.irwrite = bus.irwrite;
        o.memwrite = bus.memwrite; o.regdst = bus.regdst;   o.regwrite = bus.regwrite;
        o.alusrca = bus.alusrca;   o.alusrcb = bus.alusrcb; o.pcsrc = bus.pcsrc;
        o.alu = bus.alucontrl;     o.srw = bus.select_regwrite;
        o.hi_w = bus.hi_write;     o.lo_w = bus.lo_write;
        o.hi_s = bus.hi_select;    o.lo_s = bus.lo_select;
        o.busy = bus.md_busy;      o.illegal = bus.illegal;
        return o;
    endfunction

    // Monitor: every cycle with a pending expectation is checked mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            obs_t a;
            e = sb.pop_front();
            a = sample();
            n_vec++;
            if (a !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.tag, a, e.v);
            end
        end
    end

    task automatic push(input string tag, input string st, input logic [3:0] alu = 4'b0,
                        input logic z = 1'b0, input logic [1:0] sel = 2'b00);
        exp_t e;
        e.tag = {tag, ".", st};
        e.v   = model(st, alu, z, sel);
        sb.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Called 2ns into a FETCH cycle; returns 2ns into the next FETCH cycle.
    task automatic run(input string tag, input logic [31:0] ins, input logic z, input string s2,
                       input string s3 = "", input string s4 = "",
                       input logic [3:0] alu = 4'b0, input logic [1:0] sel = 2'b00);
        int n;
        bus.instr = ins;
        bus.zero  = z;
        push(tag, "FETCH");
        push(tag, "DECODE");
        push(tag, s2, alu, z, sel);
        n = 3;
        if (s3 != "") begin push(tag, s3, alu, z, sel); n++; end
        if (s4 != "") begin push(tag, s4, alu, z, sel); n++; end
        cycles(n);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.instr = '0;
        bus.zero  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        push("por", "RST");
        cycles(1);

        // Reset asserted during FETCH for two edges.
        bus.instr = 32'h8C080004;
        push("rst_fetch", "FETCH");
        rst_n = 1'b0;
        cycles(1);
        push("rst_fetch", "RST");
        cycles(1);
        rst_n = 1'b1;
        push("rst_fetch", "RST");
        cycles(1);

        run("lw",   32'h8C080004, 1'b0, "MEMADR", "MEMRD", "MEMWB");
        run("sw",   32'hAC080004, 1'b0, "MEMADR", "MEMWR");
        run("add",  32'h01095020, 1'b0, "EXEC", "ALUWB", "", 4'b0010);
        run("sub",  32'h01095022, 1'b0, "EXEC", "ALUWB", "", 4'b0110);
        run("nor",  32'h01095027, 1'b0, "EXEC", "ALUWB", "", 4'b0100);
        run("slt",  32'h0109502A, 1'b0, "EXEC", "ALUWB", "", 4'b0111);
        run("sll",  32'h00094080, 1'b0, "EXEC", "ALUWB", "", 4'b1000);
        run("srav", 32'h01095007, 1'b0, "EXEC", "ALUWB", "", 4'b1101);
        run("addi", 32'h21080005, 1'b0, "ADDIEX", "ADDIWB");
        run("beq1", 32'h11090002, 1'b1, "BRANCH");
        run("beq0", 32'h11090002, 1'b0, "BRANCH");
        run("j",    32'h08000010, 1'b0, "JUMP");
        run("jr",   32'h01000008, 1'b0, "JR");
        run("ilop", 32'hFC000000, 1'b0, "ILLEGAL");
        run("ilfn", 32'h0000003F, 1'b0, "ILLEGAL");
`ifdef MIPS_MC_HILO_EN
        run("mfhi", 32'h00004010, 1'b0, "HLRD", "", "", 4'b0, 2'b10);
        run("mflo", 32'h00004012, 1'b0, "HLRD", "", "", 4'b0, 2'b11);
        run("mthi", 32'h01000011, 1'b0, "HLWR_HI");
        run("mtlo", 32'h01000013, 1'b0, "HLWR_LO");

        bus.instr = 32'h01090018;
        push("mult", "FETCH");
        push("mult", "DECODE");
        for (int i = 0; i < 3; i++) push("mult", "MDWAIT");
        push("mult", "MDLAST", 4'b0, 1'b0, 2'b11);
        cycles(6);

        bus.instr = 32'h0109001A;
        push("div_rst", "FETCH");
        push("div_rst", "DECODE");
        push("div_rst", "MDWAIT");
        cycles(3);
        push("div_rst", "MDWAIT");
        rst_n = 1'b0;
        cycles(1);
        push("div_rst", "RST");
        rst_n = 1'b1;
        cycles(1);

        bus.instr = 32'h0109001A;
        push("div", "FETCH");
        push("div", "DECODE");
        for (int i = 0; i < 3; i++) push("div", "MDWAIT");
        push("div", "MDLAST", 4'b0, 1'b0, 2'b10);
        cycles(6);
`else
        run("mfhi_off", 32'h00004010, 1'b0, "ILLEGAL");
        run("mult_off", 32'h01090018, 1'b0, "ILLEGAL");
`endif
        run("add_end", 32'h01095020, 1'b0, "EXEC", "ALUWB", "", 4'b0010);

        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
